trig_arbiter: RTL and testbench

- Sits downstream of the per-pad debounced trigger stages.
- Collects single-cycle trigger pulses from NUM_CH pads, enforces a per-channel retrigger lockout, and holds accepted triggers as pending.
- Serializes pending triggers round-robin into a valid/ready stream of channel IDs for the sample-playback voice allocator.
- Reports coalesced or locked-out triggers through a saturating drop counter.

---
 rtl/trig_pkg.sv | 14 +
 rtl/trig_lockout.sv | 43 ++++
 rtl/trig_arbiter.sv | 118 +++++++++++
 tb/tb_trig_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared trigger-path definitions: pad count, pad ID type and the default
// retrigger lockout derived from the system clock period.
package trig_pkg;

   localparam int unsigned NUM_PADS      = 8;
   localparam int unsigned CLK_PERIOD_NS = 20;
   localparam int unsigned LOCKOUT_MS    = 2;

   // Same ms-to-cycles conversion the debouncer uses.
   localparam int unsigned LOCKOUT_CYCLES_DFLT = LOCKOUT_MS * 1_000_000 / CLK_PERIOD_NS;

   typedef logic [$clog2(NUM_PADS)-1:0] pad_id_t;

endpackage

// File: rtl/trig_lockout.sv
// Per-channel retrigger lockout: down-counter plus the accept/drop decision
// for one trigger input.
module trig_lockout
   import trig_pkg::*;
#(
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DFLT
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   input  logic pending,
   output logic accept,
   output logic drop
);

   // 0 and 1 both mean no lockout; the counter then never leaves zero.
   localparam int unsigned LOAD  = (LOCKOUT_CYCLES > 1) ? LOCKOUT_CYCLES - 1 : 0;
   localparam int unsigned CNT_W = (LOAD > 1) ? $clog2(LOAD + 1) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             idle;

   always_comb begin
      idle   = (cnt_q == '0);
      accept = trig & idle & ~pending;
      drop   = trig & ~accept;
      cnt_d  = cnt_q;
      if (accept) begin
         cnt_d = CNT_W'(LOAD);
      end else if (!idle) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/trig_arbiter.sv
// Trigger arbiter: lockout-filtered pending bits, round-robin serialised into
// a valid/ready stream of channel IDs, with a saturating drop counter.
module trig_arbiter
   import trig_pkg::*;
#(
   parameter int unsigned NUM_CH         = NUM_PADS,
   parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DFLT,
   parameter int unsigned DROP_CNT_W     = 8,
   localparam int unsigned CH_W          = $clog2(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_CH-1:0]     trig_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH_W-1:0]       out_ch,
   output logic [NUM_CH-1:0]     pending,
   output logic [DROP_CNT_W-1:0] drop_count
);

   localparam int unsigned POP_W = CH_W + 1;
   localparam int unsigned SUM_W = ((DROP_CNT_W > POP_W) ? DROP_CNT_W : POP_W) + 1;

   function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                               input logic [CH_W-1:0]   last);
      logic [CH_W-1:0] sel;
      logic            found;
      int unsigned     idx;
      sel   = last;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         idx = (32'(last) + k) % NUM_CH;
         if (!found && req[idx]) begin
            sel   = CH_W'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   function automatic logic [POP_W-1:0] popcount(input logic [NUM_CH-1:0] v);
      logic [POP_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt = cnt + POP_W'(v[i]);
      end
      return cnt;
   endfunction

   logic [NUM_CH-1:0]     pending_q, pending_d, accept, drop, grant_clr;
   logic                  out_valid_q, out_valid_d, load;
   logic [CH_W-1:0]       out_ch_q, out_ch_d, last_grant_q, last_grant_d, pick;
   logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
   logic [SUM_W-1:0]      drop_sum;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lock
      trig_lockout #(
         .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
      ) u_lock (
         .clk    (clk),
         .rst    (rst),
         .trig   (trig_in[i]),
         .pending(pending_q[i]),
         .accept (accept[i]),
         .drop   (drop[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q    <= '0;
         out_valid_q  <= 1'b0;
         out_ch_q     <= '0;
         last_grant_q <= CH_W'(NUM_CH - 1);
         drop_count_q <= '0;
      end else begin
         pending_q    <= pending_d;
         out_valid_q  <= out_valid_d;
         out_ch_q     <= out_ch_d;
         last_grant_q <= last_grant_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_comb begin
      load         = ~out_valid_q | out_ready;
      pick         = rr_pick(pending_q, last_grant_q);
      out_valid_d  = out_valid_q;
      out_ch_d     = out_ch_q;
      last_grant_d = last_grant_q;
      grant_clr    = '0;
      if (load) begin
         if (|pending_q) begin
            out_valid_d     = 1'b1;
            out_ch_d        = pick;
            last_grant_d    = pick;
            grant_clr[pick] = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end
      // A fresh accept re-pends even the channel just granted.
      pending_d = (pending_q & ~grant_clr) | accept;

      drop_sum = SUM_W'(drop_count_q) + SUM_W'(popcount(drop));
      if (|drop_sum[SUM_W-1:DROP_CNT_W]) begin
         drop_count_d = '1;
      end else begin
         drop_count_d = drop_sum[DROP_CNT_W-1:0];
      end
   end

   assign out_valid  = out_valid_q;
   assign out_ch     = out_ch_q;
   assign pending    = pending_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_trig_arbiter.sv
// Directed bench for trig_arbiter: expected grants (channel and cycle) are queued
// by the stimulus and popped by per-DUT monitors on each handshake.
module tb_trig_arbiter;

   typedef struct {
      int ch;
      int cyc;
   } exp_t;

   logic       clk;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   // DUT a: lockout disabled; DUT b: 10-cycle lockout.
   logic       a_rst, a_ready, a_valid;
   logic [7:0] a_trig, a_pend, a_drop;
   logic [2:0] a_ch;
   logic       b_rst, b_ready, b_valid;
   logic [7:0] b_trig, b_pend, b_drop;
   logic [2:0] b_ch;

   exp_t       qa[$];
   exp_t       qb[$];
   logic       a_hold = 1'b0, b_hold = 1'b0;
   logic [2:0] a_hold_ch = '0, b_hold_ch = '0;

   trig_arbiter #(
      .NUM_CH(8), .LOCKOUT_CYCLES(1), .DROP_CNT_W(8)
   ) u_dut_a (
      .clk(clk), .rst(a_rst), .trig_in(a_trig), .out_valid(a_valid),
      .out_ready(a_ready), .out_ch(a_ch), .pending(a_pend), .drop_count(a_drop)
   );

   trig_arbiter #(
      .NUM_CH(8), .LOCKOUT_CYCLES(10), .DROP_CNT_W(8)
   ) u_dut_b (
      .clk(clk), .rst(b_rst), .trig_in(b_trig), .out_valid(b_valid),
      .out_ready(b_ready), .out_ch(b_ch), .pending(b_pend), .drop_count(b_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [7:0] t);
      a_rst = 1'b1; b_rst = 1'b1;
      a_trig = t;   b_trig = t;
      a_ready = 1'b0; b_ready = 1'b0;
      tick();
      a_rst = 1'b0; b_rst = 1'b0;
      a_trig = '0;  b_trig = '0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (a_hold && !a_rst) begin
         chk("a_hold_valid", int'(a_valid), 1);
         chk("a_hold_ch", int'(a_ch), int'(a_hold_ch));
      end
      if (!a_rst && a_valid && a_ready) begin
         if (qa.size() == 0) begin
            chk("a_unexpected_grant", int'(a_ch), -1);
         end else begin
            e = qa.pop_front();
            chk("a_grant_ch", int'(a_ch), e.ch);
            chk("a_grant_cyc", cyc, e.cyc);
         end
      end
      a_hold    <= !a_rst && a_valid && !a_ready;
      a_hold_ch <= a_ch;
   end

   always @(negedge clk) begin
      exp_t e;
      if (b_hold && !b_rst) begin
         chk("b_hold_valid", int'(b_valid), 1);
         chk("b_hold_ch", int'(b_ch), int'(b_hold_ch));
      end
      if (!b_rst && b_valid && b_ready) begin
         if (qb.size() == 0) begin
            chk("b_unexpected_grant", int'(b_ch), -1);
         end else begin
            e = qb.pop_front();
            chk("b_grant_ch", int'(b_ch), e.ch);
            chk("b_grant_cyc", cyc, e.cyc);
         end
      end
      b_hold    <= !b_rst && b_valid && !b_ready;
      b_hold_ch <= b_ch;
   end

   initial begin
      int t0;

      // Reset state; triggers during the reset cycle must leave no trace.
      do_reset(8'hFF);
      chk("rst_a_valid", int'(a_valid), 0);
      chk("rst_a_ch", int'(a_ch), 0);
      chk("rst_a_pend", int'(a_pend), 0);
      chk("rst_a_drop", int'(a_drop), 0);
      chk("rst_b_valid", int'(b_valid), 0);
      chk("rst_b_pend", int'(b_pend), 0);
      chk("rst_b_drop", int'(b_drop), 0);

      // Single trigger, latency 2 (b, lockout counter must be clear after reset).
      t0 = cyc;
      qb.push_back('{ch: 3, cyc: t0 + 2});
      b_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) chk("t1_pend_c1", int'(b_pend), 8'h08);
         if (c == 2) begin
            chk("t1_valid_c2", int'(b_valid), 1);
            chk("t1_ch_c2", int'(b_ch), 3);
            chk("t1_pend_c2", int'(b_pend), 0);
         end
         if (c == 3) chk("t1_valid_c3", int'(b_valid), 0);
         if (c == 4) chk("t1_drop", int'(b_drop), 0);
         b_trig = (c == 0) ? 8'h08 : 8'h00;
         tick();
      end
      chk("t1_queue_empty", qb.size(), 0);

      // Lockout: ch2 at 0, 5, 10 with a 10-cycle lockout.
      do_reset(8'h00);
      t0 = cyc;
      qb.push_back('{ch: 2, cyc: t0 + 2});
      qb.push_back('{ch: 2, cyc: t0 + 12});
      b_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (c == 5) chk("t4_drop_c5", int'(b_drop), 0);
         if (c == 6) chk("t4_drop_c6", int'(b_drop), 1);
         if (c == 14) begin
            chk("t4_drop_end", int'(b_drop), 1);
            chk("t4_pend_end", int'(b_pend), 0);
         end
         b_trig = (c == 0 || c == 5 || c == 10) ? 8'h04 : 8'h00;
         tick();
      end
      chk("t4_queue_empty", qb.size(), 0);
      b_ready = 1'b0;

      // Three simultaneous triggers drain one per cycle.
      do_reset(8'h00);
      t0 = cyc;
      qa.push_back('{ch: 0, cyc: t0 + 2});
      qa.push_back('{ch: 2, cyc: t0 + 3});
      qa.push_back('{ch: 5, cyc: t0 + 4});
      a_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c == 1) chk("t2_pend_c1", int'(a_pend), 8'h25);
         if (c == 2) chk("t2_pend_c2", int'(a_pend), 8'h24);
         if (c == 5) begin
            chk("t2_valid_c5", int'(a_valid), 0);
            chk("t2_drop", int'(a_drop), 0);
         end
         a_trig = (c == 0) ? 8'h25 : 8'h00;
         tick();
      end
      chk("t2_queue_empty", qa.size(), 0);

      // Backpressure: ch1 held while ch4 waits.
      do_reset(8'h00);
      t0 = cyc;
      qa.push_back('{ch: 1, cyc: t0 + 10});
      qa.push_back('{ch: 4, cyc: t0 + 11});
      for (int c = 0; c < 13; c++) begin
         if (c == 2) begin
            chk("t3_valid_c2", int'(a_valid), 1);
            chk("t3_ch_c2", int'(a_ch), 1);
         end
         if (c == 9) chk("t3_pend_c9", int'(a_pend), 8'h10);
         if (c == 12) chk("t3_valid_c12", int'(a_valid), 0);
         a_ready = (c >= 10);
         a_trig  = (c == 0) ? 8'h02 : (c == 3) ? 8'h10 : 8'h00;
         tick();
      end
      chk("t3_queue_empty", qa.size(), 0);

      // Re-pend of the presented channel, coalescing, then drop saturation.
      do_reset(8'h00);
      t0 = cyc;
      for (int c = 0; c < 311; c++) begin
         if (c == 2) begin
            chk("t5_valid_c2", int'(a_valid), 1);
            chk("t5_ch_c2", int'(a_ch), 6);
            chk("t5_pend_c2", int'(a_pend), 0);
         end
         if (c == 6) chk("t5_pend_c6", int'(a_pend), 8'h40);
         if (c == 8) chk("t5_drop_c8", int'(a_drop), 1);
         if (c == 262) chk("t5_drop_c262", int'(a_drop), 254);
         if (c == 309) chk("t5_drop_sat", int'(a_drop), 255);
         if (c == 310) chk("t5_drop_sat_hold", int'(a_drop), 255);
         a_ready = 1'b0;
         a_trig  = (c == 0 || c == 5 || c == 7 || (c >= 9 && c <= 308)) ? 8'h40 : 8'h00;
         tick();
      end
      t0 = cyc;
      qa.push_back('{ch: 6, cyc: t0});
      qa.push_back('{ch: 6, cyc: t0 + 1});
      for (int c = 0; c < 4; c++) begin
         if (c == 3) chk("t5_valid_drained", int'(a_valid), 0);
         a_ready = 1'b1;
         a_trig  = 8'h00;
         tick();
      end
      chk("t5_queue_empty", qa.size(), 0);

      // Fairness with all channels retriggering, then reset mid-stream.
      do_reset(8'h00);
      t0 = cyc;
      for (int k = 0; k < 12; k++) qa.push_back('{ch: k % 8, cyc: t0 + 2 + k});
      qa.push_back('{ch: 3, cyc: t0 + 17});
      qa.push_back('{ch: 5, cyc: t0 + 18});
      for (int c = 0; c < 23; c++) begin
         if (c == 13) chk("t6_drop_c13", int'(a_drop), 85);
         if (c == 15) begin
            chk("t6_valid_after_rst", int'(a_valid), 0);
            chk("t6_pend_after_rst", int'(a_pend), 0);
            chk("t6_drop_after_rst", int'(a_drop), 0);
         end
         a_ready = 1'b1;
         a_rst   = (c == 14);
         a_trig  = (c <= 14) ? 8'hFF : (c == 15) ? 8'h28 : 8'h00;
         tick();
      end
      chk("t6_queue_empty", qa.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
